quad_stim_gen: RTL and testbench
================================

Name: quad_stim_gen

Overview:
- Quadrature encoder stimulus generator: the transmit side of the rotary-encoder interface.
- Converts a commanded signed step count plus an optional button press into clean A/B phase waveforms (p1, p2) and a btn level.
- Drives the encoder-decoder input pins in bench and loopback builds; also usable as an on-board test source selected at fpga_top.

Parameters:
- STEP_DIV, 1000, clocks per quadrature step (one phase transition); legal >= 2
- BTN_HOLD, 500, clocks btn is held high, and also the clocks of the low gap after release; legal >= 1
- CNT_W, 8, width of the pos and presses counters

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  generator can accept a command
- cmd_steps  input  8  signed step count, two's complement; sign gives direction
- cmd_press  input  1  perform one button press after the steps
- p1  output  1  quadrature phase A
- p2  output  1  quadrature phase B
- btn  output  1  emulated button level, active-high
- busy  output  1  command in progress
- pos  output  CNT_W  running signed step total emitted, wraps
- presses  output  CNT_W  count of btn rising edges emitted, wraps

Behaviour:
- Reset: one clock (clk); synchronous, active-high reset (rst).
- Reset values: p1=0, p2=0, btn=0, pos=0, presses=0, busy=0, cmd_ready=0. State IDLE. cmd_ready rises the first cycle after rst deasserts.
- rst asserted mid-command aborts at the next edge. {p1,p2} jumps to 00, which may look like a skipped step downstream; this is accepted behaviour.
- Phase order {p1,p2}, forward (positive steps): 00->01->11->10->00. Reverse: 00->10->11->01->00. Exactly one bit changes per step.
- Phase persists between commands; it is never re-zeroed except by rst.
- Handshake: accept on cmd_valid && cmd_ready. cmd_ready=1 only in IDLE with rst low. cmd_ready=0 from the cycle after accept until return to IDLE. Inputs are sampled only at accept.
- Magnitude = |cmd_steps| as 8-bit unsigned; -128 gives 128 steps.
- A command with steps=0 and press=0 is accepted and is a no-op. State stays IDLE, cmd_ready stays 1.
- FSM states: IDLE, STEP, PRESS, GAP.
  - IDLE->STEP if magnitude!=0; IDLE->PRESS if magnitude==0 and press=1.
  - STEP: timer loads STEP_DIV-1 on entry. When it reaches 0, advance the phase one position, pos+=1 (forward) or pos-=1 (reverse), decrement remaining, reload.
  - The first transition occurs exactly STEP_DIV cycles after the accept edge. Consecutive transitions are STEP_DIV cycles apart.
  - When the last step is emitted: go to PRESS if press=1, else IDLE.
  - PRESS: btn=1 for exactly BTN_HOLD cycles; presses+=1 on the cycle btn rises. Then go to GAP.
  - GAP: btn=0 for BTN_HOLD cycles, then IDLE.
- busy=1 in every state except IDLE.
- Counter widths: pos and presses wrap modulo 2^CNT_W. Timer width = $clog2(max(STEP_DIV, BTN_HOLD)).
- All outputs are registered; no combinational path from cmd_* to p1/p2/btn.

Decomposition:
- Package quad_pkg:
  - phase constants PH_00, PH_01, PH_11, PH_10
  - functions next_phase(ph, dir)
  - FSM state enum
- One sub-module, interval_timer: load value, down-count, done pulse. Shared by STEP, PRESS and GAP timing.

Test Plan (bench uses STEP_DIV=4, BTN_HOLD=3):
- After reset, accept steps=+3, press=0 -> {p1,p2}=01,11,10 at cycles 4,8,12 after accept; pos=3; cmd_ready returns 1 at cycle 13.
- Then steps=-2 -> phases 11,01 (continuing from 10); pos=1; each transition changes one bit only.
- steps=0, press=1 -> btn high for cycles 1..3, low for 4..6; presses=1; busy low, ready high after the gap.
- steps=-128 -> 128 transitions; pos wraps 1->129 (0x81); final phase = start phase (128 mod 4 = 0).
- rst asserted after 2 of 5 steps -> next edge p1=p2=0, pos=0, busy=0; a new command is accepted normally.
- cmd_valid held high while busy -> no second accept until IDLE; a back-to-back command is accepted on the cycle ready is 1.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types for the quadrature stimulus generator: FSM states, phase
// encodings and the phase-advance function.
package quad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_PRESS = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // dir=0 walks 00->01->11->10 (forward), dir=1 walks the reverse cycle.
  function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic dir);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = dir ? PH_10 : PH_01;
      PH_01:   nxt = dir ? PH_00 : PH_11;
      PH_11:   nxt = dir ? PH_01 : PH_10;
      default: nxt = dir ? PH_11 : PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_stim_gen_timer.sv
// Down-counting interval timer: load a value, count to zero, hold there.
// done_o is high whenever the count sits at zero.
module interval_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/quad_stim_gen.sv
// Quadrature encoder stimulus generator: turns a signed step command plus an
// optional button press into A/B phase waveforms and a button level.
module quad_stim_gen
  import quad_pkg::*;
#(
  parameter int STEP_DIV = 1000,
  parameter int BTN_HOLD = 500,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_steps,
  input  logic             cmd_press,
  output logic             p1,
  output logic             p2,
  output logic             btn,
  output logic             busy,
  output logic [CNT_W-1:0] pos,
  output logic [CNT_W-1:0] presses
);

  localparam int TMAX = (STEP_DIV > BTN_HOLD) ? STEP_DIV : BTN_HOLD;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] STEP_RELOAD = TW'(STEP_DIV - 1);
  localparam logic [TW-1:0] HOLD_RELOAD = TW'(BTN_HOLD - 1);

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic             press_q, press_d;
  logic [7:0]       rem_q, rem_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] presses_q, presses_d;
  logic             btn_q, btn_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_done;
  logic             accept;
  logic [7:0]       mag;

  // Two's-complement negate of -128 yields 0x80, i.e. 128 steps.
  assign mag    = cmd_steps[7] ? (8'd0 - cmd_steps) : cmd_steps;
  assign accept = cmd_valid && ready_q;

  interval_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    press_d  = press_q;
    rem_d    = rem_q;
    phase_d  = phase_q;
    pos_d    = pos_q;
    tmr_load = 1'b0;
    tmr_val  = STEP_RELOAD;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dir_d   = cmd_steps[7];
          press_d = cmd_press;
          rem_d   = mag;
          if (mag != 8'd0) begin
            state_d  = ST_STEP;
            tmr_load = 1'b1;
          end else if (cmd_press) begin
            state_d  = ST_PRESS;
            tmr_load = 1'b1;
            tmr_val  = HOLD_RELOAD;
          end
        end
      end
      ST_STEP: begin
        if (tmr_done) begin
          phase_d  = next_phase(phase_q, dir_q);
          pos_d    = dir_q ? (pos_q - 1'b1) : (pos_q + 1'b1);
          rem_d    = rem_q - 8'd1;
          tmr_load = 1'b1;
          if (rem_q == 8'd1) begin
            state_d = press_q ? ST_PRESS : ST_IDLE;
            tmr_val = HOLD_RELOAD;
          end
        end
      end
      ST_PRESS: begin
        if (tmr_done) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = HOLD_RELOAD;
        end
      end
      default: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // btn trails the PRESS state by one register stage, so it is high for
  // exactly the PRESS duration and the counter bumps on its rising edge.
  assign btn_d     = (state_q == ST_PRESS);
  assign presses_d = (btn_d && !btn_q) ? (presses_q + 1'b1) : presses_q;
  assign busy_d    = (state_d != ST_IDLE);
  assign ready_d   = (state_q == ST_IDLE) && (state_d == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= 1'b0;
      press_q   <= 1'b0;
      rem_q     <= 8'd0;
      phase_q   <= PH_00;
      pos_q     <= '0;
      presses_q <= '0;
      btn_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      press_q   <= press_d;
      rem_q     <= rem_d;
      phase_q   <= phase_d;
      pos_q     <= pos_d;
      presses_q <= presses_d;
      btn_q     <= btn_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign p1        = phase_q[1];
  assign p2        = phase_q[0];
  assign btn       = btn_q;
  assign busy      = busy_q;
  assign cmd_ready = ready_q;
  assign pos       = pos_q;
  assign presses   = presses_q;

endmodule

// File: tb/tb_quad_stim_gen.sv
// Self-checking bench for quad_stim_gen: fixed and random commands checked
// cycle by cycle against a timeline model derived from the command rules.
module tb_quad_stim_gen;

  localparam int SD = 4;
  localparam int BH = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_steps;
  logic       cmd_press;
  logic       p1, p2, btn, busy;
  logic [7:0] pos, presses;

  int checks = 0;
  int errors = 0;

  // Reference model state carried between commands.
  int ph_idx = 0;
  int pos_m  = 0;
  int pres_m = 0;
  logic [1:0] fwd_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  quad_stim_gen #(.STEP_DIV(SD), .BTN_HOLD(BH), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_press (cmd_press),
    .p1        (p1),
    .p2        (p2),
    .btn       (btn),
    .busy      (busy),
    .pos       (pos),
    .presses   (presses)
  );

  always #5 clk = ~clk;

  function automatic int wrap4(input int x);
    return ((x % 4) + 4) % 4;
  endfunction

  // Offer one command, then check every cycle up to one past the return to
  // idle. keep_valid leaves cmd_valid high (with junk data) after accept.
  task automatic run_command(input int steps, input bit press, input bit keep_valid);
    int mag, sgn, t_press, t_end, done_n, waited;
    bit noop, exp_btn, exp_busy, exp_ready;
    logic [1:0] exp_ph, prev_ph;
    logic [7:0] exp_pos, exp_pres;
    waited = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    cmd_valid = 1'b1;
    cmd_steps = 8'(steps);
    cmd_press = press;
    @(posedge clk);
    #1;
    if (keep_valid) begin
      cmd_steps = 8'($urandom);
      cmd_press = 1'($urandom_range(0, 1));
    end else begin
      cmd_valid = 1'b0;
    end

    mag     = (steps < 0) ? -steps : steps;
    sgn     = (steps < 0) ? -1 : 1;
    noop    = (mag == 0) && !press;
    t_press = mag * SD;
    t_end   = noop ? 0 : (press ? t_press + 2 * BH : t_press);
    prev_ph = fwd_tab[wrap4(ph_idx)];

    for (int k = 0; k <= t_end + 1; k++) begin
      done_n    = (k / SD > mag) ? mag : k / SD;
      exp_ph    = fwd_tab[wrap4(ph_idx + sgn * done_n)];
      exp_pos   = 8'(pos_m + sgn * done_n);
      exp_btn   = press && (k >= t_press + 1) && (k <= t_press + BH);
      exp_pres  = 8'(pres_m + ((press && k >= t_press + 1) ? 1 : 0));
      exp_busy  = (k < t_end);
      exp_ready = noop ? 1'b1 : (k > t_end);

      checks++;
      if ({p1, p2} !== exp_ph) begin
        errors++;
        $display("FAIL phase steps=%0d k=%0d: got %b required %b", steps, k, {p1, p2}, exp_ph);
      end
      checks++;
      if ($countones({p1, p2} ^ prev_ph) > 1) begin
        errors++;
        $display("FAIL one_bit steps=%0d k=%0d: %b -> %b changes two bits", steps, k, prev_ph, {p1, p2});
      end
      prev_ph = {p1, p2};
      checks++;
      if (pos !== exp_pos) begin
        errors++;
        $display("FAIL pos steps=%0d k=%0d: got %0d required %0d", steps, k, pos, exp_pos);
      end
      checks++;
      if (btn !== exp_btn) begin
        errors++;
        $display("FAIL btn steps=%0d k=%0d: got %b required %b", steps, k, btn, exp_btn);
      end
      checks++;
      if (presses !== exp_pres) begin
        errors++;
        $display("FAIL presses steps=%0d k=%0d: got %0d required %0d", steps, k, presses, exp_pres);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy steps=%0d k=%0d: got %b required %b", steps, k, busy, exp_busy);
      end
      checks++;
      if (cmd_ready !== exp_ready) begin
        errors++;
        $display("FAIL ready steps=%0d k=%0d: got %b required %b", steps, k, cmd_ready, exp_ready);
      end
      if (k <= t_end) begin
        @(posedge clk);
        #1;
      end
    end

    ph_idx = wrap4(ph_idx + sgn * mag);
    pos_m  = (pos_m + sgn * mag) & 255;
    pres_m = (pres_m + (press ? 1 : 0)) & 255;
    $display("cmd steps=%0d press=%0d: done after %0d cycles, phase=%b pos=%0d presses=%0d",
             steps, press, t_end, {p1, p2}, pos, presses);
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_steps = 8'd0;
    cmd_press = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({p1, p2, btn, busy, cmd_ready} !== 5'b0 || pos !== 8'd0 || presses !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: p1p2=%b btn=%b busy=%b ready=%b pos=%0d presses=%0d required all 0",
               {p1, p2}, btn, busy, cmd_ready, pos, presses);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_reset: ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
    $display("reset: ready=%b busy=%b", cmd_ready, busy);
  endtask

  task automatic test_fwd_steps;
    run_command(3, 1'b0, 1'b0);
  endtask

  task automatic test_rev_steps;
    run_command(-2, 1'b0, 1'b0);
  endtask

  task automatic test_press;
    run_command(0, 1'b1, 1'b0);
    run_command(0, 1'b0, 1'b0);
    run_command(1, 1'b1, 1'b0);
  endtask

  task automatic test_wrap;
    run_command(-128, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort;
    logic [7:0] exp_pos;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_steps = 8'd5;
    cmd_press = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2 * SD) @(posedge clk);
    #1;
    exp_pos = 8'(pos_m + 2);
    checks++;
    if (pos !== exp_pos) begin
      errors++;
      $display("FAIL abort_mid_pos: got %0d required %0d", pos, exp_pos);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({p1, p2} !== 2'b00 || pos !== 8'd0 || busy !== 1'b0 || cmd_ready !== 1'b0 || presses !== 8'd0) begin
      errors++;
      $display("FAIL abort_reset: p1p2=%b pos=%0d busy=%b ready=%b presses=%0d required 00/0/0/0/0",
               {p1, p2}, pos, busy, cmd_ready, presses);
    end
    @(negedge clk);
    rst    = 1'b0;
    ph_idx = 0;
    pos_m  = 0;
    pres_m = 0;
    $display("abort: reset after 2 of 5 steps, pos=%0d busy=%b", pos, busy);
    run_command(2, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    int s;
    bit pr;
    for (int i = 0; i < 8; i++) begin
      s  = int'($urandom_range(0, 20)) - 10;
      pr = 1'($urandom_range(0, 1));
      run_command(s, pr, 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    run_command(2, 1'b0, 1'b1);
    run_command(-1, 1'b1, 1'b1);
    run_command(3, 1'b0, 1'b1);
    run_command(-2, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_fwd_steps;
    test_rev_steps;
    test_press;
    test_wrap;
    test_reset_abort;
    test_random;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
